// File: rtl/pipe_pkg.sv
// Shared types and per-boundary default widths for the pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } stage_state_e;

  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned IF_ID_CTRL_W  = 2;
  localparam int unsigned ID_EX_DATA_W  = 111;
  localparam int unsigned ID_EX_CTRL_W  = 10;
  localparam int unsigned EX_MEM_DATA_W = 101;
  localparam int unsigned EX_MEM_CTRL_W = 6;
  localparam int unsigned MEM_WB_DATA_W = 69;
  localparam int unsigned MEM_WB_CTRL_W = 3;

  localparam int unsigned DEF_PERF_W = 16;

  localparam logic [ID_EX_CTRL_W-1:0] ID_EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_slot.sv
// One data+ctrl+valid register. Load wins over clear; clear keeps data but restores the bubble ctrl.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W      = ID_EX_DATA_W,
  parameter int unsigned        CTRL_W      = ID_EX_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= CTRL_BUBBLE;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= CTRL_BUBBLE;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid, bubble insertion and flush.
// Optional STAGE_PERF_EN adds saturating bubble/stall counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W      = ID_EX_DATA_W,
  parameter int unsigned        CTRL_W      = ID_EX_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}}
`ifdef STAGE_PERF_EN
  ,
  parameter int unsigned        PERF_W      = DEF_PERF_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef STAGE_PERF_EN
  ,
  output logic [PERF_W-1:0] bubble_cnt,
  output logic [PERF_W-1:0] stall_cnt
`endif
);

  stage_state_e state_q, state_d;
  logic         in_ready_q;

  logic              accept, send;
  logic [CTRL_W-1:0] in_ctrl_eff;

  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic [DATA_W-1:0] main_load_data;
  logic [CTRL_W-1:0] main_load_ctrl;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              unused_skid_valid;

  assign unused_skid_valid = skid_valid;

  assign accept      = in_valid && in_ready_q;
  assign send        = out_valid && out_ready;
  assign in_ctrl_eff = bubble ? CTRL_BUBBLE : in_ctrl;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = StEmpty;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StOne;
            main_load = 1'b1;
          end
        end
        StOne: begin
          if (accept && send) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = StFull;
            skid_load = 1'b1;
          end else if (send) begin
            state_d    = StEmpty;
            main_clear = 1'b1;
          end
        end
        StFull: begin
          if (send) begin
            state_d        = StOne;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_d    = StEmpty;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_load_data = main_from_skid ? skid_data : in_data;
  assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  assign in_ready = in_ready_q;

  pipe_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_load_data),
    .load_ctrl (main_load_ctrl),
    .valid     (out_valid),
    .data      (out_data),
    .ctrl      (out_ctrl)
  );

  pipe_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (in_data),
    .load_ctrl (in_ctrl_eff),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );

`ifdef STAGE_PERF_EN
  logic [PERF_W-1:0] bubble_cnt_q, stall_cnt_q;

  // A beat dropped by flush is not counted as an accepted bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (accept && bubble && !flush && (bubble_cnt_q != {PERF_W{1'b1}})) begin
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
      if (out_valid && !out_ready && (stall_cnt_q != {PERF_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; counter checks run when STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 111;
  localparam int unsigned CTRL_W = 10;
  localparam int unsigned PERF_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              bubble;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
`ifdef STAGE_PERF_EN
  logic [PERF_W-1:0] bubble_cnt;
  logic [PERF_W-1:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE ({CTRL_W{1'b0}})
`ifdef STAGE_PERF_EN
    ,
    .PERF_W      (PERF_W)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .bubble    (bubble),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef STAGE_PERF_EN
    ,
    .bubble_cnt (bubble_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change #1 after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    bubble    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_data", 128'(out_data), 128'd0);
    check("rst_out_ctrl", 128'(out_ctrl), 128'd0);
`ifdef STAGE_PERF_EN
    check("rst_bubble_cnt", 128'(bubble_cnt), 128'd0);
    check("rst_stall_cnt", 128'(stall_cnt), 128'd0);
`endif
    rst = 1'b0;

    // Streaming at full rate
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DATA_W'(i);
      in_ctrl = CTRL_W'(i + 16);
      tick();
      check("stream_data", 128'(out_data), 128'(i));
      check("stream_ctrl", 128'(out_ctrl), 128'(i + 16));
      check("stream_valid", 128'(out_valid), 128'd1);
      check("stream_ready", 128'(in_ready), 128'd1);
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", 128'(out_valid), 128'd0);
    check("drain_ctrl", 128'(out_ctrl), 128'd0);
    check("drain_data_hold", 128'(out_data), 128'd8);

    // Backpressure fills the skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'(128'h11);
    in_ctrl   = 10'h011;
    tick();
    check("bp_a_valid", 128'(out_valid), 128'd1);
    check("bp_a_data", 128'(out_data), 128'h11);
    check("bp_a_ready", 128'(in_ready), 128'd1);
    in_data = DATA_W'(128'h22);
    in_ctrl = 10'h022;
    tick();
    check("bp_full_ready", 128'(in_ready), 128'd0);
    check("bp_full_data", 128'(out_data), 128'h11);
    in_data = DATA_W'(128'h33);
    in_ctrl = 10'h033;
    tick();
    check("bp_c_held_ready", 128'(in_ready), 128'd0);
    check("bp_c_held_data", 128'(out_data), 128'h11);
    out_ready = 1'b1;
    tick();
    check("bp_b_data", 128'(out_data), 128'h22);
    check("bp_b_ctrl", 128'(out_ctrl), 128'h022);
    check("bp_ready_back", 128'(in_ready), 128'd1);
    tick();
    check("bp_c_data", 128'(out_data), 128'h33);
    check("bp_c_valid", 128'(out_valid), 128'd1);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 128'(out_valid), 128'd0);

    // Bubble on accept zeroes ctrl, keeps data
    in_valid = 1'b1;
    in_data  = DATA_W'(128'hDEADBEEF);
    in_ctrl  = 10'h3FF;
    bubble   = 1'b1;
    tick();
    check("bub_valid", 128'(out_valid), 128'd1);
    check("bub_data", 128'(out_data), 128'hDEADBEEF);
    check("bub_ctrl", 128'(out_ctrl), 128'd0);
    // Bubble with no incoming beat does nothing
    in_valid = 1'b0;
    tick();
    check("bub_ignored_valid", 128'(out_valid), 128'd0);
    bubble = 1'b0;

    // Flush while FULL drops held beats and the presented one
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'(128'h55);
    in_ctrl   = 10'h001;
    tick();
    in_data = DATA_W'(128'h66);
    in_ctrl = 10'h002;
    tick();
    check("fl_full_ready", 128'(in_ready), 128'd0);
    in_data = DATA_W'(128'h44);
    in_ctrl = 10'h004;
    flush   = 1'b1;
    tick();
    check("fl_valid", 128'(out_valid), 128'd0);
    check("fl_ready", 128'(in_ready), 128'd1);
    check("fl_ctrl", 128'(out_ctrl), 128'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("fl_no_ghost_valid", 128'(out_valid), 128'd0);
    check("fl_data_hold", 128'(out_data), 128'h55);

    // Flush in ONE with a presented beat also drops it
    in_valid = 1'b1;
    in_data  = DATA_W'(128'h77);
    in_ctrl  = 10'h007;
    tick();
    in_data = DATA_W'(128'h88);
    flush   = 1'b1;
    tick();
    check("fl1_valid", 128'(out_valid), 128'd0);
    check("fl1_data", 128'(out_data), 128'h77);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Reset mid-transfer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'(128'h99);
    tick();
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    check("mrst_valid", 128'(out_valid), 128'd0);
    check("mrst_data", 128'(out_data), 128'd0);
    check("mrst_ready", 128'(in_ready), 128'd1);
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;

`ifdef STAGE_PERF_EN
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bubble    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DATA_W'(i + 1);
      tick();
    end
    check("perf_bubble3", 128'(bubble_cnt), 128'd3);
    check("perf_stall0", 128'(stall_cnt), 128'd0);
    bubble    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("perf_stall_sat", 128'(stall_cnt), 128'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("perf_fl_bubble", 128'(bubble_cnt), 128'd3);
    check("perf_fl_stall", 128'(stall_cnt), 128'd15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
